dvi_frame_sequencer: RTL and testbench
======================================

Name: dvi_frame_sequencer

Overview:
- Timing controller that sequences the three TMDS channel encoders (blue = ch0, green = ch1, red = ch2) for DVI output.
- Runs horizontal and vertical counters and drives each encoder's DE, CTRL and 8-bit data inputs.
- Pulls pixels from an upstream source through a ready/valid handshake.
- Timing never stalls: a missing pixel is replaced by a fill colour and flagged.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level
- V_POL, 0, vsync active level
- FILL_RGB, 24'h0000FF, {r,g,b} substituted on underflow

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  run request
- pix_valid  in  1  upstream pixel present
- pix_r  in  8  upstream red
- pix_g  in  8  upstream green
- pix_b  in  8  upstream blue
- pix_ready  out  1  pixel consumed this cycle
- de  out  1  data enable, common to all three encoders
- ctrl0  out  2  ch0 control: [0]=hsync, [1]=vsync
- ctrl1  out  2  ch1 control, always 2'b00
- ctrl2  out  2  ch2 control, always 2'b00
- data0  out  8  ch0 (blue) data
- data1  out  8  ch1 (green) data
- data2  out  8  ch2 (red) data
- frame_start  out  1  one-clock pulse with first active pixel of a frame
- underflow  out  1  sticky underflow flag
- clr_underflow  in  1  clears underflow

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: hcnt and vcnt are 12 bits wide. hcnt wraps from H_TOTAL-1 to 0 and increments vcnt; vcnt wraps from V_TOTAL-1 to 0.
- Region order within a line and a frame: active, front porch, sync, back porch. Active region is hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- hsync_raw = H_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
- vsync_raw uses the same rule on vcnt. It is held for whole lines and changes only at hcnt = 0.
- FSM states:
  - IDLE: counters held at 0.
  - RUN: counters advance every clock.
  - DRAIN: counters advance; entered when en = 0 is seen in RUN.
- FSM transitions:
  - IDLE -> RUN when en = 1; counters advance from the next clock.
  - RUN -> DRAIN when en = 0.
  - DRAIN -> RUN if en returns to 1 before the frame wraps.
  - DRAIN -> IDLE at the wrap (hcnt = H_TOTAL-1, vcnt = V_TOTAL-1). A frame is never truncated.
- Handshake:
  - pix_ready is combinational and equals (state != IDLE) & active(hcnt, vcnt).
  - A pixel is consumed when pix_ready = 1 in a cycle. It is transferred if pix_valid = 1.
  - Upstream must advance only on pix_ready & pix_valid.
- Output stage: all outputs except pix_ready are registered, so latency is exactly 1 clock from counter state to outputs.
  - de follows pix_ready, delayed one clock.
  - ctrl0 = {vsync_raw, hsync_raw} for the same counter state.
  - While de = 1, ctrl0 still carries sync levels; they are ignored by the encoders.
- Data outputs:
  - Transferred pixel: data0/1/2 = pix_b/pix_g/pix_r.
  - Consumed without pix_valid: data outputs take FILL_RGB and underflow is set.
  - de = 0: data outputs are 0.
- underflow:
  - Set has priority over clr_underflow in the same cycle.
  - Otherwise clr_underflow clears it.
- frame_start is registered high for the pixel at hcnt = 0, vcnt = 0.
- In IDLE: de = 0, ctrl0 = {~V_POL, ~H_POL}, data = 0, frame_start = 0.
- Reset: asynchronous to IDLE with counters = 0 and pix_ready = 0.
  - Registered outputs after reset: de = 0, ctrl0 = {~V_POL, ~H_POL}, ctrl1 = ctrl2 = 0, data0/1/2 = 0, frame_start = 0, underflow = 0.
  - Reset mid-frame aborts immediately; no drain.

Test Plan:
(Small config for all: H 4/1/2/1 (H_TOTAL = 8), V 3/1/1/1 (V_TOTAL = 6), POL = 0 → 48 clocks per frame.)
- Reset then en = 1, pix_valid = 1, counting pixels → 12 de cycles per frame, 4 per line, on lines 0-2. hsync low for 2 clocks starting 5 clocks after line start. vsync low for all 8 clocks of line 4. frame_start high once per 48 clocks.
- Pixel ramp on pix_b (0, 1, 2, ...) with pix_valid = 1 → data0 matches the ramp one clock after each pix_ready. data1/data2 track pix_g/pix_r. ctrl1 = ctrl2 = 0 throughout.
- pix_valid = 0 at the 3rd active pixel of line 1 → that output is {data2, data1, data0} = {00, 00, FF}. underflow rises and stays set. Asserting clr_underflow in a cycle with no new underflow clears it.
- en dropped at hcnt = 3, vcnt = 1 → frame completes all 48 clocks, then IDLE with de = 0 and ctrl0 = 2'b11. en re-raised during DRAIN → no gap between frames.
- rst pulsed mid active line → all outputs return to reset values asynchronously. After release with en = 1, the first de comes 1 clock after RUN starts, with frame_start = 1.
- underflow set and clr_underflow in the same cycle → underflow = 1.

Source files
------------

// File: rtl/dvi_frame_sequencer.sv
// DVI timing controller: runs h/v counters, pulls pixels over ready/valid and
// drives DE, CTRL and data for the three TMDS channel encoders.
module dvi_frame_sequencer #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter logic [23:0] FILL_RGB = 24'h0000FF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pix_valid,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic       pix_ready,
  output logic       de,
  output logic [1:0] ctrl0,
  output logic [1:0] ctrl1,
  output logic [1:0] ctrl2,
  output logic [7:0] data0,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic       frame_start,
  output logic       underflow,
  input  logic       clr_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic        active;
  logic        line_end;
  logic        frame_end;
  logic        hsync_raw;
  logic        vsync_raw;
  logic        consume_empty;

  assign active    = (hcnt < 12'(H_ACTIVE)) && (vcnt < 12'(V_ACTIVE));
  assign line_end  = (hcnt == 12'(H_TOTAL - 1));
  assign frame_end = (vcnt == 12'(V_TOTAL - 1));

  assign hsync_raw = (hcnt >= 12'(H_ACTIVE + H_FP) && hcnt < 12'(H_ACTIVE + H_FP + H_SYNC))
                     ? H_POL : ~H_POL;
  // vcnt only moves at line wrap, so vsync naturally holds for whole lines
  assign vsync_raw = (vcnt >= 12'(V_ACTIVE + V_FP) && vcnt < 12'(V_ACTIVE + V_FP + V_SYNC))
                     ? V_POL : ~V_POL;

  assign pix_ready     = (state != IDLE) && active;
  assign consume_empty = pix_ready && !pix_valid;

  assign ctrl1 = 2'b00;
  assign ctrl2 = 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      de          <= 1'b0;
      ctrl0       <= {~V_POL, ~H_POL};
      data0       <= '0;
      data1       <= '0;
      data2       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hcnt <= '0;
          vcnt <= '0;
          if (en) state <= RUN;
        end
        default: begin
          if (line_end) begin
            hcnt <= '0;
            vcnt <= frame_end ? 12'd0 : vcnt + 12'd1;
          end else begin
            hcnt <= hcnt + 12'd1;
          end
          // a drained frame always runs to its last clock before stopping
          if (state == RUN) begin
            if (!en) state <= DRAIN;
          end else if (en) begin
            state <= RUN;
          end else if (line_end && frame_end) begin
            state <= IDLE;
          end
        end
      endcase

      de          <= pix_ready;
      ctrl0       <= (state == IDLE) ? {~V_POL, ~H_POL} : {vsync_raw, hsync_raw};
      frame_start <= pix_ready && (hcnt == 12'd0) && (vcnt == 12'd0);

      if (pix_ready && pix_valid) begin
        data0 <= pix_b;
        data1 <= pix_g;
        data2 <= pix_r;
      end else if (pix_ready) begin
        data0 <= FILL_RGB[7:0];
        data1 <= FILL_RGB[15:8];
        data2 <= FILL_RGB[23:16];
      end else begin
        data0 <= '0;
        data1 <= '0;
        data2 <= '0;
      end

      if (consume_empty)      underflow <= 1'b1;
      else if (clr_underflow) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvi_frame_sequencer.sv
// Bench for dvi_frame_sequencer on a small 8x6 timing: directed vectors,
// multi-cycle sequences and a randomized run against a frame-position model.
module tb_dvi_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_r = '0, pix_g = '0, pix_b = '0;
  logic       clr_underflow = 1'b0;
  logic       pix_ready, de, frame_start, underflow;
  logic [1:0] ctrl0, ctrl1, ctrl2;
  logic [7:0] data0, data1, data2;

  int n_chk = 0;
  int n_fail = 0;

  dvi_frame_sequencer #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .FILL_RGB(24'h0000FF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_ready(pix_ready),
    .de(de), .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .data0(data0), .data1(data1), .data2(data2),
    .frame_start(frame_start), .underflow(underflow),
    .clr_underflow(clr_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, valid, clr;
    logic [7:0]  r, g, b;
    logic        e_de;
    logic [1:0]  e_ctrl;
    logic [23:0] e_rgb;
    logic        e_fs, e_uf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pix_valid = 1'b0; clr_underflow = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input logic e_de, input logic [1:0] e_ctrl,
                             input logic [23:0] e_rgb, input logic e_fs, input logic e_uf);
    chk({tag, ".de"}, de, e_de);
    chk({tag, ".ctrl0"}, ctrl0, e_ctrl);
    chk({tag, ".ctrl12"}, {ctrl1, ctrl2}, 4'h0);
    chk({tag, ".rgb"}, {data2, data1, data0}, e_rgb);
    chk({tag, ".frame_start"}, frame_start, e_fs);
    chk({tag, ".underflow"}, underflow, e_uf);
  endtask

  vec_t vecs[10];

  // model state: mode 0 = stopped, 1 = running, 2 = finishing frame; pos = clock within frame
  int   m_mode, m_pos;
  logic m_uf;

  initial begin
    int de_cnt, fs_cnt, hs_cnt, vs_cnt;

    vecs[0] = '{1,1,0, 8'h00,8'h00,8'h00, 0,2'b11,24'h000000, 0,0};
    vecs[1] = '{1,1,0, 8'h30,8'h20,8'h10, 1,2'b11,24'h302010, 1,0};
    vecs[2] = '{1,1,0, 8'h31,8'h21,8'h11, 1,2'b11,24'h312111, 0,0};
    vecs[3] = '{1,0,0, 8'h55,8'h55,8'h55, 1,2'b11,24'h0000FF, 0,1};
    vecs[4] = '{1,1,1, 8'h33,8'h23,8'h13, 1,2'b11,24'h332313, 0,0};
    vecs[5] = '{1,0,0, 8'h00,8'h00,8'h00, 0,2'b11,24'h000000, 0,0};
    vecs[6] = '{1,0,0, 8'h00,8'h00,8'h00, 0,2'b10,24'h000000, 0,0};
    vecs[7] = '{1,0,0, 8'h00,8'h00,8'h00, 0,2'b10,24'h000000, 0,0};
    vecs[8] = '{1,0,0, 8'h00,8'h00,8'h00, 0,2'b11,24'h000000, 0,0};
    vecs[9] = '{1,0,1, 8'h00,8'h00,8'h00, 1,2'b11,24'h0000FF, 0,1};

    do_reset();
    chk_outputs("reset", 1'b0, 2'b11, 24'h0, 1'b0, 1'b0);
    chk("reset.pix_ready", pix_ready, 1'b0);

    for (int i = 0; i < 10; i++) begin
      en = vecs[i].en; pix_valid = vecs[i].valid; clr_underflow = vecs[i].clr;
      pix_r = vecs[i].r; pix_g = vecs[i].g; pix_b = vecs[i].b;
      @(posedge clk); @(negedge clk);
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_de, vecs[i].e_ctrl, vecs[i].e_rgb,
                  vecs[i].e_fs, vecs[i].e_uf);
    end
    clr_underflow = 1'b0;

    // two full frames: timing shape counts
    do_reset();
    en = 1'b1; pix_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    de_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 96; i++) begin
      @(posedge clk); @(negedge clk);
      de_cnt += int'(de); fs_cnt += int'(frame_start);
      hs_cnt += int'(!ctrl0[0]); vs_cnt += int'(!ctrl0[1]);
    end
    chk("frames.de_count", de_cnt, 24);
    chk("frames.fs_count", fs_cnt, 2);
    chk("frames.hsync_low", hs_cnt, 24);
    chk("frames.vsync_low", vs_cnt, 16);

    // drop en at hcnt=3, vcnt=1 (frame position 11); frame must finish
    do_reset();
    en = 1'b1; pix_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin @(posedge clk); @(negedge clk); end
    chk("drain.ready_at_drop", pix_ready, 1'b1);
    en = 1'b0;
    de_cnt = 0;
    for (int i = 0; i < 37; i++) begin
      @(posedge clk); @(negedge clk);
      de_cnt += int'(de);
    end
    chk("drain.de_count", de_cnt, 5);
    chk("drain.idle_ready", pix_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin @(posedge clk); @(negedge clk); end
    chk_outputs("drain.idle", 1'b0, 2'b11, 24'h0, 1'b0, 1'b0);

    // async reset mid active line
    do_reset();
    en = 1'b1; pix_valid = 1'b1; pix_b = 8'hAA;
    for (int i = 0; i < 3; i++) begin @(posedge clk); @(negedge clk); end
    chk("midreset.pre_de", de, 1'b1);
    rst = 1'b1;
    #1;
    chk_outputs("midreset.async", 1'b0, 2'b11, 24'h0, 1'b0, 1'b0);
    chk("midreset.pix_ready", pix_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("restart.first_de", de, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("restart.second_de", de, 1'b1);
    chk("restart.frame_start", frame_start, 1'b1);

    // randomized run against a frame-position model
    do_reset();
    m_mode = 0; m_pos = 0; m_uf = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int h, v;
      logic rdy, e_de, e_fs;
      logic [1:0]  e_ctrl;
      logic [23:0] e_rgb;
      if ($urandom_range(0, 29) == 0) en = 1'($urandom_range(0, 1));
      pix_valid = ($urandom_range(0, 9) != 0);
      clr_underflow = ($urandom_range(0, 19) == 0);
      pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);

      h = m_pos % 8; v = m_pos / 8;
      rdy = (m_mode != 0) && (h < 4) && (v < 3);
      chk("rand.pix_ready", pix_ready, rdy);
      e_de = rdy;
      e_fs = rdy && (m_pos == 0);
      e_ctrl = (m_mode == 0) ? 2'b11 : {~(v == 4), ~(h == 5 || h == 6)};
      e_rgb = !rdy ? 24'h0 : (pix_valid ? {pix_r, pix_g, pix_b} : 24'h0000FF);
      if (rdy && !pix_valid) m_uf = 1'b1;
      else if (clr_underflow) m_uf = 1'b0;

      if (m_mode == 0) begin
        if (en) m_mode = 1;
      end else begin
        if (m_mode == 1 && !en) m_mode = 2;
        else if (m_mode == 2 && en) m_mode = 1;
        else if (m_mode == 2 && m_pos == 47) m_mode = 0;
        m_pos = (m_pos + 1) % 48;
      end

      @(posedge clk); @(negedge clk);
      chk_outputs("rand", e_de, e_ctrl, e_rgb, e_fs, m_uf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
